ps2_key_sequencer: RTL

//   Drains the ps2_keyboard receive FIFO via its ready/nextdata_n handshake.

---
 rtl/ps2_key_sequencer_pkg.sv | 21 ++
 rtl/ps2_key_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ps2_key_sequencer_pkg.sv
// Shared definitions for the PS/2 key sequencer: FSM state encoding and
// the set-2 scancode bytes that are handled specially.
package ps2_key_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_DECODE = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERRF  = 8'hFF;

    function automatic logic is_err_code(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_ERRF);
    endfunction

endpackage

// File: rtl/ps2_key_sequencer.sv
// Drains the ps2_keyboard FIFO one byte at a time, folds E0/F0 prefixes into
// single key events and hands them to one consumer over valid/ready.
module ps2_key_sequencer
    import ps2_key_sequencer_pkg::*;
#(
    parameter int CNT_W        = 3,
    parameter bit SUPPRESS_RPT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_ready,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_overflow,
    output logic             ps2_nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_make,
    output logic             held_valid,
    output logic [7:0]       held_code,
    output logic [CNT_W-1:0] press_count,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    state_t           state, state_n;
    logic [7:0]       byte_r, byte_n;
    logic             brk, brk_n, ext, ext_n;
    logic             held_ext, held_ext_n;
    logic             nextdata_n_n;
    logic             ev_valid_n, ev_ext_n, ev_make_n;
    logic [7:0]       ev_code_n;
    logic             held_valid_n;
    logic [7:0]       held_code_n;
    logic [CNT_W-1:0] press_count_n;
    logic             ovf_sticky_n;
    logic             make;
    logic             is_repeat;

    assign make      = !brk;
    assign is_repeat = SUPPRESS_RPT && make && held_valid &&
                       (held_code == byte_r) && (held_ext == ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            byte_r         <= 8'h00;
            brk            <= 1'b0;
            ext            <= 1'b0;
            ps2_nextdata_n <= 1'b1;
            ev_valid       <= 1'b0;
            ev_code        <= 8'h00;
            ev_ext         <= 1'b0;
            ev_make        <= 1'b0;
            held_valid     <= 1'b0;
            held_code      <= 8'h00;
            held_ext       <= 1'b0;
            press_count    <= '0;
            ovf_sticky     <= 1'b0;
        end else begin
            state          <= state_n;
            byte_r         <= byte_n;
            brk            <= brk_n;
            ext            <= ext_n;
            ps2_nextdata_n <= nextdata_n_n;
            ev_valid       <= ev_valid_n;
            ev_code        <= ev_code_n;
            ev_ext         <= ev_ext_n;
            ev_make        <= ev_make_n;
            held_valid     <= held_valid_n;
            held_code      <= held_code_n;
            held_ext       <= held_ext_n;
            press_count    <= press_count_n;
            ovf_sticky     <= ovf_sticky_n;
        end
    end

    always_comb begin
        state_n       = state;
        byte_n        = byte_r;
        brk_n         = brk;
        ext_n         = ext;
        nextdata_n_n  = 1'b1;
        ev_valid_n    = ev_valid;
        ev_code_n     = ev_code;
        ev_ext_n      = ev_ext;
        ev_make_n     = ev_make;
        held_valid_n  = held_valid;
        held_code_n   = held_code;
        held_ext_n    = held_ext;
        press_count_n = press_count;
        // A new overflow wins over a clear arriving in the same cycle.
        ovf_sticky_n  = ps2_overflow | (ovf_sticky & ~ovf_clr);

        case (state)
            ST_IDLE: begin
                if (ps2_ready) begin
                    byte_n       = ps2_data;
                    nextdata_n_n = 1'b0;
                    state_n      = ST_POP;
                end
            end
            ST_POP: begin
                state_n = ST_DECODE;
            end
            ST_DECODE: begin
                state_n = ST_IDLE;
                if (byte_r == SC_BREAK) begin
                    brk_n = 1'b1;
                end else if (byte_r == SC_EXT) begin
                    ext_n = 1'b1;
                end else if (is_err_code(byte_r) || is_repeat) begin
                    brk_n = 1'b0;
                    ext_n = 1'b0;
                end else begin
                    ev_code_n  = byte_r;
                    ev_ext_n   = ext;
                    ev_make_n  = make;
                    ev_valid_n = 1'b1;
                    state_n    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // Nothing is popped here, so queued bytes wait in the FIFO.
                if (ev_ready) begin
                    ev_valid_n = 1'b0;
                    brk_n      = 1'b0;
                    ext_n      = 1'b0;
                    state_n    = ST_IDLE;
                    if (ev_make) begin
                        held_valid_n  = 1'b1;
                        held_code_n   = ev_code;
                        held_ext_n    = ev_ext;
                        press_count_n = press_count + 1'b1;
                    end else if (held_valid && held_code == ev_code &&
                                 held_ext == ev_ext) begin
                        held_valid_n = 1'b0;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
